// File: rtl/dp_multimod_nco.sv
// Multi-mode (AM/FM/PM/CW) numerically controlled oscillator.
// Four register stages separate an accepted sample from its output; the phase accumulator closes in stage 1.
module dp_multimod_nco #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned DW_IN  = 16,
    parameter int unsigned DW_OUT = 14,
    parameter int unsigned LUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  i_data,
    input  logic              val_in,
    input  logic              sync_clr,
    input  logic [1:0]        c_mode,
    input  logic              c_comp_dac,
    input  logic [ACC_W-1:0]  frec_por,
    input  logic [15:0]       im_am,
    input  logic [15:0]       im_fm,
    output logic [DW_OUT-1:0] o_data,
    output logic [ACC_W-1:0]  o_phase,
    output logic              val_out
);

    localparam int unsigned QW    = LUT_AW + 2;
    localparam int unsigned QTR   = 1 << LUT_AW;
    localparam int unsigned PM_SH = 32 - ACC_W;
    localparam logic [LUT_AW:0] QTR_V = (LUT_AW + 1)'(QTR);
    localparam logic signed [DW_OUT+16:0] SAT_HI = (DW_OUT + 17)'((1 << (DW_OUT - 1)) - 1);
    localparam logic signed [DW_OUT+16:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        MODE_AM = 2'b00,
        MODE_FM = 2'b01,
        MODE_PM = 2'b10,
        MODE_CW = 2'b11
    } mode_t;

    // Quarter-wave sine table (entries 0..QTR inclusive); contents fixed at elaboration.
    function automatic logic [DW_OUT-2:0] sin_entry(input int k);
        real amp;
        real ang;
        amp = real'((1 << (DW_OUT - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << QW);
        return (DW_OUT - 1)'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [DW_OUT-2:0] rom [QTR+1];

    for (genvar g = 0; g < QTR + 1; g++) begin : g_rom
        assign rom[g] = sin_entry(g);
    end

    // Stage 0: modulation arithmetic on the live inputs
    mode_t              mode_in;
    logic signed [31:0] m_fm;
    logic signed [31:0] m_am;
    logic signed [31:0] sc_am;
    logic signed [31:0] env_raw;
    logic [ACC_W-1:0]   sc_fm;
    logic [ACC_W-1:0]   pm_off;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   inc;
    logic [ACC_W-1:0]   phase0;
    logic [15:0]        env0;
    logic [ACC_W-1:0]   acc;

    assign mode_in = mode_t'(c_mode);
    assign m_fm    = 32'($signed(i_data)) * 32'($signed({1'b0, im_fm}));
    assign m_am    = 32'($signed(i_data)) * 32'($signed({1'b0, im_am}));
    assign sc_fm   = ACC_W'(m_fm >>> 15);
    assign pm_off  = (mode_in == MODE_PM) ? ACC_W'(m_fm >>> PM_SH) : '0;
    assign base    = sync_clr ? '0 : acc;
    assign inc     = frec_por + ((mode_in == MODE_FM) ? sc_fm : '0);
    assign phase0  = base + pm_off;
    assign sc_am   = m_am >>> 15;
    assign env_raw = sc_am + 32'sd32768;

    always_comb begin
        env0 = env_raw[15:0];
        if (env_raw < 32'sd0) begin
            env0 = '0;
        end else if (env_raw > 32'sd65535) begin
            env0 = '1;
        end
    end

    // Stage 1: accumulator update and sample capture
    logic             v1;
    logic [ACC_W-1:0] p1;
    logic [15:0]      env1;
    logic             am1;
    logic             comp1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            v1    <= 1'b0;
            p1    <= '0;
            env1  <= '0;
            am1   <= 1'b0;
            comp1 <= 1'b0;
        end else begin
            v1 <= val_in;
            if (val_in) begin
                acc   <= base + inc;
                p1    <= phase0;
                env1  <= env0;
                am1   <= (mode_in == MODE_AM);
                comp1 <= c_comp_dac;
            end
        end
    end

    // Stage 2: table lookup; second and fourth quadrants read the table mirrored
    logic [QW-1:0]     q1;
    logic [LUT_AW:0]   idx1;
    logic [LUT_AW:0]   addr1;
    logic              v2;
    logic [DW_OUT-2:0] mag2;
    logic              neg2;
    logic [ACC_W-1:0]  p2;
    logic [15:0]       env2;
    logic              am2;
    logic              comp2;

    assign q1    = p1[ACC_W-1 -: QW];
    assign idx1  = {1'b0, q1[LUT_AW-1:0]};
    assign addr1 = q1[LUT_AW] ? (QTR_V - idx1) : idx1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v2    <= 1'b0;
            mag2  <= '0;
            neg2  <= 1'b0;
            p2    <= '0;
            env2  <= '0;
            am2   <= 1'b0;
            comp2 <= 1'b0;
        end else begin
            v2    <= v1;
            mag2  <= rom[addr1];
            neg2  <= q1[QW-1];
            p2    <= p1;
            env2  <= env1;
            am2   <= am1;
            comp2 <= comp1;
        end
    end

    // Stage 3: signed carrier and AM envelope product
    logic signed [DW_OUT-1:0]  mag_s;
    logic signed [DW_OUT-1:0]  s2;
    logic                      v3;
    logic signed [DW_OUT-1:0]  s3;
    logic signed [DW_OUT+16:0] prod3;
    logic [ACC_W-1:0]          p3;
    logic                      am3;
    logic                      comp3;

    assign mag_s = {1'b0, mag2};
    assign s2    = neg2 ? -mag_s : mag_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v3    <= 1'b0;
            s3    <= '0;
            prod3 <= '0;
            p3    <= '0;
            am3   <= 1'b0;
            comp3 <= 1'b0;
        end else begin
            v3    <= v2;
            s3    <= s2;
            prod3 <= (DW_OUT + 17)'(s2) * (DW_OUT + 17)'($signed({1'b0, env2}));
            p3    <= p2;
            am3   <= am2;
            comp3 <= comp2;
        end
    end

    // Stage 4: scale, saturate, select, optional offset-binary; outputs hold between strobes
    logic signed [DW_OUT+16:0] am_sh;
    logic signed [DW_OUT-1:0]  am_sat;
    logic signed [DW_OUT-1:0]  res;
    logic [DW_OUT-1:0]         out_word;

    assign am_sh = prod3 >>> 16;

    always_comb begin
        am_sat = am_sh[DW_OUT-1:0];
        if (am_sh > SAT_HI) begin
            am_sat = {1'b0, {(DW_OUT - 1){1'b1}}};
        end else if (am_sh < SAT_LO) begin
            am_sat = {1'b1, {(DW_OUT - 1){1'b0}}};
        end
    end

    assign res      = am3 ? am_sat : s3;
    assign out_word = comp3 ? {~res[DW_OUT-1], res[DW_OUT-2:0]} : res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_out <= 1'b0;
            o_data  <= '0;
            o_phase <= '0;
        end else begin
            val_out <= v3;
            if (v3) begin
                o_data  <= out_word;
                o_phase <= p3;
            end
        end
    end

endmodule

// File: tb/tb_dp_multimod_nco.sv
// Bench for dp_multimod_nco: arithmetic reference model with a latency queue,
// per-cycle output comparison, directed literal cases and randomized traffic.
module tb_dp_multimod_nco;

    localparam int ACC_W  = 24;
    localparam int DW_IN  = 16;
    localparam int DW_OUT = 14;
    localparam int LUT_AW = 10;
    localparam longint MASK = 64'h0000_0000_00FF_FFFF;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        val_in;
    logic        sync_clr;
    logic [1:0]  c_mode;
    logic        c_comp_dac;
    logic [23:0] frec_por;
    logic [15:0] im_am;
    logic [15:0] im_fm;
    logic [13:0] o_data;
    logic [23:0] o_phase;
    logic        val_out;

    always #5 clk = ~clk;

    dp_multimod_nco #(
        .ACC_W (ACC_W),
        .DW_IN (DW_IN),
        .DW_OUT(DW_OUT),
        .LUT_AW(LUT_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .val_in    (val_in),
        .sync_clr  (sync_clr),
        .c_mode    (c_mode),
        .c_comp_dac(c_comp_dac),
        .frec_por  (frec_por),
        .im_am     (im_am),
        .im_fm     (im_fm),
        .o_data    (o_data),
        .o_phase   (o_phase),
        .val_out   (val_out)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [63:0] d14(input int v);
        logic [13:0] t;
        t = 14'(v);
        return 64'(t);
    endfunction

    // ---------------- reference model ----------------
    function automatic int sine_ref(input int q);
        real r;
        r = 8191.0 * $sin(2.0 * PI * real'(q) / 4096.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic void model_sample(input logic [1:0] mode, input logic sync, input logic comp,
                                         input logic [15:0] d, input logic [15:0] am, input logic [15:0] fm,
                                         input logic [23:0] frec, inout longint acc,
                                         output logic [13:0] data, output logic [23:0] phase);
        longint mfm, mam, base, inc, p, env, r;
        int s;
        mfm  = longint'($signed(d)) * longint'(fm);
        mam  = longint'($signed(d)) * longint'(am);
        base = sync ? 64'sd0 : acc;
        inc  = longint'(frec) + ((mode == 2'b01) ? (mfm >>> 15) : 64'sd0);
        acc  = (base + inc) & MASK;
        p    = (base + ((mode == 2'b10) ? (mfm >>> 8) : 64'sd0)) & MASK;
        s    = sine_ref(int'(p >> 12));
        r    = longint'(s);
        if (mode == 2'b00) begin
            env = 32768 + (mam >>> 15);
            if (env < 0) env = 0;
            if (env > 65535) env = 65535;
            r = (longint'(s) * env) >>> 16;
            if (r > 8191) r = 8191;
            if (r < -8192) r = -8192;
        end
        data = 14'(r);
        if (comp) data[13] = ~data[13];
        phase = 24'(p);
    endfunction

    typedef struct packed {
        int          due;
        logic [13:0] data;
        logic [23:0] phase;
    } ent_t;

    ent_t        pend[$];
    longint      acc_m     = 0;
    bit          model_on  = 1'b0;
    logic        exp_val   = 1'b0;
    logic [13:0] exp_data  = '0;
    logic [23:0] exp_phase = '0;

    initial begin
        ent_t        e;
        logic [13:0] md;
        logic [23:0] mp;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b0) begin
                model_on  = 1'b1;
                pend.delete();
                acc_m     = 0;
                exp_val   = 1'b0;
                exp_data  = '0;
                exp_phase = '0;
            end else if (model_on) begin
                exp_val = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e         = pend.pop_front();
                    exp_val   = 1'b1;
                    exp_data  = e.data;
                    exp_phase = e.phase;
                end
                if (val_in === 1'b1) begin
                    model_sample(c_mode, sync_clr, c_comp_dac, i_data, im_am, im_fm, frec_por, acc_m, md, mp);
                    pend.push_back('{due: cyc + 3, data: md, phase: mp});
                end
            end
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    logic [13:0] cap_data[$];
    logic [23:0] cap_phase[$];
    int          cap_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("val_out", 64'(val_out), 64'(exp_val));
                chk("o_data", 64'(o_data), 64'(exp_data));
                chk("o_phase", 64'(o_phase), 64'(exp_phase));
            end
            if (val_out === 1'b1) begin
                cap_data.push_back(o_data);
                cap_phase.push_back(o_phase);
                cap_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [63:0] capd(input int i);
        if (i < cap_data.size()) return 64'(cap_data[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] capp(input int i);
        if (i < cap_phase.size()) return 64'(cap_phase[i]);
        return 'x;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic s, input logic [1:0] mode, input logic comp, input logic [15:0] d,
                        input logic [15:0] am, input logic [15:0] fm, input logic [23:0] frec);
        @(negedge clk);
        rst = 1'b1; val_in = 1'b1; sync_clr = s; c_mode = mode; c_comp_dac = comp;
        i_data = d; im_am = am; im_fm = fm; frec_por = frec;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            val_in = 1'b0; sync_clr = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; val_in = 1'b1; sync_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1; val_in = 1'b0;
        cap_data.delete(); cap_phase.delete(); cap_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", tests);
        $fatal(1);
    end

    int          cw_d[4]  = '{0, 8191, 0, -8191};
    logic [23:0] cw_p[4]  = '{24'h000000, 24'h400000, 24'h800000, 24'hC00000};
    logic [15:0] am_in[3] = '{16'h0000, 16'h7FFF, 16'h8000};
    int          am_ex[3] = '{4095, 8190, 0};
    int          fm_p[4]  = '{0, 16383, 32766, 49149};
    int          sy_p[6]  = '{0, 1000, 2000, 3000, 0, 1000};

    initial begin
        longint      a;
        logic [13:0] pd;
        logic [23:0] pp;
        int          first_cyc;

        rst = 1'b0; val_in = 1'b0; sync_clr = 1'b0; c_mode = 2'b11; c_comp_dac = 1'b0;
        i_data = '0; im_am = '0; im_fm = '0; frec_por = '0;

        // Pin the reference model to hand-computed values
        chk("pin_sin_q1024", 64'(sine_ref(1024)), 64'(8191));
        chk("pin_sin_q3072", 64'(sine_ref(3072)), 64'(-8191));
        a = 0;
        model_sample(2'b01, 1'b1, 1'b0, 16'd16384, 16'd0, 16'd32767, 24'd0, a, pd, pp);
        chk("pin_fm_acc", a, 64'd16383);
        a = 64'h400000;
        model_sample(2'b00, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 16'd0, 24'h400000, a, pd, pp);
        chk("pin_am_full", 64'(pd), d14(8190));
        a = 0;
        model_sample(2'b10, 1'b0, 1'b0, 16'd16384, 16'd0, 16'd32767, 24'd0, a, pd, pp);
        chk("pin_pm_phase", 64'(pp), 64'd2097088);
        a = 0;
        model_sample(2'b11, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 24'd0, a, pd, pp);
        chk("pin_comp_zero", 64'(pd), 64'h2000);

        // Reset state
        do_reset();
        chk("reset_o_data", 64'(o_data), 64'd0);
        chk("reset_o_phase", 64'(o_phase), 64'd0);
        chk("reset_val_out", 64'(val_out), 64'd0);

        // CW carrier, val_in every cycle
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'h400000);
        first_cyc = cyc;
        for (int i = 1; i < 8; i++) send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'h400000);
        idle(6);
        chk("cw_count", 64'(cap_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("cw_data", capd(i), d14(cw_d[i % 4]));
            chk("cw_phase", capp(i), 64'(cw_p[i % 4]));
        end
        chk("latency", (cap_cyc.size() > 0) ? 64'(cap_cyc[0] - first_cyc) : 'x, 64'd4);

        // Offset-binary output
        do_reset();
        send(1'b0, 2'b11, 1'b1, 16'd0, 16'd0, 16'd0, 24'h400000);
        send(1'b0, 2'b11, 1'b1, 16'd0, 16'd0, 16'd0, 24'h400000);
        idle(6);
        chk("comp_phase0", capd(0), 64'h2000);
        chk("comp_phase1", capd(1), 64'h3FFF);

        // AM at phase 2^22
        for (int k = 0; k < 3; k++) begin
            do_reset();
            send(1'b1, 2'b00, 1'b0, am_in[k], 16'h7FFF, 16'd0, 24'h400000);
            send(1'b0, 2'b00, 1'b0, am_in[k], 16'h7FFF, 16'd0, 24'h400000);
            idle(6);
            chk("am_phase", capp(1), 64'h400000);
            chk("am_data", capd(1), d14(am_ex[k]));
        end

        // FM phase walk
        do_reset();
        send(1'b1, 2'b01, 1'b0, 16'd16384, 16'd0, 16'h7FFF, 24'd0);
        for (int i = 1; i < 4; i++) send(1'b0, 2'b01, 1'b0, 16'd16384, 16'd0, 16'h7FFF, 24'd0);
        idle(6);
        for (int i = 0; i < 4; i++) chk("fm_phase", capp(i), 64'(fm_p[i]));

        // sync_clr qualified by val_in; config changes between strobes ignored
        do_reset();
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        @(negedge clk);
        val_in = 1'b0; sync_clr = 1'b1; frec_por = 24'd55555; c_mode = 2'b01; i_data = 16'h7FFF; im_fm = 16'hFFFF;
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        send(1'b1, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'd1000);
        idle(6);
        for (int i = 0; i < 6; i++) chk("sync_phase", capp(i), 64'(sy_p[i]));

        // Reset with three samples in flight
        do_reset();
        for (int i = 0; i < 5; i++) send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'h400000);
        @(negedge clk);
        rst = 1'b0; val_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(6);
        chk("flush_count", 64'(cap_data.size()), 64'd2);
        chk("flush_o_data", 64'(o_data), 64'd0);
        chk("flush_o_phase", 64'(o_phase), 64'd0);
        cap_data.delete(); cap_phase.delete(); cap_cyc.delete();
        send(1'b0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 24'h400000);
        idle(6);
        chk("post_rst_count", 64'(cap_data.size()), 64'd1);
        chk("post_rst_phase", capp(0), 64'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) >= 2);
            val_in     = ($urandom_range(0, 99) < 70);
            sync_clr   = ($urandom_range(0, 9) == 0);
            c_mode     = 2'($urandom_range(0, 3));
            c_comp_dac = 1'($urandom_range(0, 1));
            i_data     = 16'($urandom);
            im_am      = 16'($urandom);
            im_fm      = 16'($urandom);
            frec_por   = 24'($urandom);
            if ($urandom_range(0, 7) == 0) i_data = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 7) == 0) im_am = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) im_fm = 16'hFFFF;
        end
        @(negedge clk);
        rst = 1'b1;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
